// File: rtl/cache_ctrl_dm_if.sv
// Bus bundle between the CPU load/store port, the cache controller and the
// BRAM bridge. The controller takes the slave view: it receives CPU requests
// and fill responses, and drives CPU completions and memory requests.
interface cache_ctrl_dm_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, cpu_busy, mem_addr, mem_wdata, mem_write, mem_req
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, cpu_busy, mem_addr, mem_wdata, mem_write, mem_req
    );
endinterface

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-back, write-allocate data cache controller with one
// 32-bit word per line. Tag/data/valid/dirty state lives in registers here.
// Memory requests from LOOKUP are driven combinationally; the fill request
// that follows a write-back is issued in the first FILL_WAIT cycle.
module cache_ctrl_dm #(
    parameter int INDEX_BITS = 4
) (
    input  logic           cpu_clk,
    input  logic           rst,
    cache_ctrl_dm_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_WAIT, FILL_WAIT, RESP} state_t;

    state_t                 state, state_n;
    logic [TAG_BITS-1:0]    tag_arr  [LINES];
    logic [31:0]            data_arr [LINES];
    logic [LINES-1:0]       valid_arr, dirty_arr;

    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_idx;
    logic                   req_we;
    logic [31:0]            req_wdata;

    logic [31:0]            mem_addr_q, mem_wdata_q, rdata_q;
    logic                   mem_write_q, fill_req_q;

    logic                   hit, victim_dirty, lookup_miss, fill_done;
    logic                   cpu_ready_c, mem_req_c;
    logic [31:0]            resp_data, victim_addr, fill_addr;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign hit          = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);
    assign victim_dirty = valid_arr[req_idx] && dirty_arr[req_idx];
    assign victim_addr  = {tag_arr[req_idx], req_idx, 2'b00};
    assign fill_addr    = {req_tag, req_idx, 2'b00};
    assign fill_done    = (state == FILL_WAIT) && bus.mem_ready && !fill_req_q;

    // Next-state and per-cycle pulse outputs; mem_ready is only honoured while waiting.
    always_comb begin
        state_n     = state;
        cpu_ready_c = 1'b0;
        mem_req_c   = 1'b0;
        lookup_miss = 1'b0;
        resp_data   = rdata_q;
        case (state)
            IDLE: begin
                if (bus.cpu_req) state_n = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_ready_c = 1'b1;
                    resp_data   = req_we ? req_wdata : data_arr[req_idx];
                    state_n     = IDLE;
                end else begin
                    mem_req_c   = 1'b1;
                    lookup_miss = 1'b1;
                    state_n     = victim_dirty ? WB_WAIT : FILL_WAIT;
                end
            end
            WB_WAIT: begin
                if (bus.mem_ready) state_n = FILL_WAIT;
            end
            FILL_WAIT: begin
                mem_req_c = fill_req_q;
                if (fill_done) state_n = RESP;
            end
            RESP: begin
                cpu_ready_c = 1'b1;
                resp_data   = data_arr[req_idx];
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cpu_ready = cpu_ready_c;
    assign bus.cpu_rdata = resp_data;
    assign bus.cpu_busy  = (state != IDLE);
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_addr  = lookup_miss ? (victim_dirty ? victim_addr : fill_addr) : mem_addr_q;
    assign bus.mem_write = lookup_miss ? victim_dirty : mem_write_q;
    assign bus.mem_wdata = (lookup_miss && victim_dirty) ? data_arr[req_idx] : mem_wdata_q;

    // State, request capture, memory-side hold registers and valid/dirty bits.
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid_arr   <= '0;
            dirty_arr   <= '0;
            req_tag     <= '0;
            req_idx     <= '0;
            req_we      <= 1'b0;
            req_wdata   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            fill_req_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state      <= state_n;
            fill_req_q <= (state == WB_WAIT) && bus.mem_ready;
            if (cpu_ready_c) rdata_q <= resp_data;
            if (state == IDLE && bus.cpu_req) begin
                req_tag   <= bus.cpu_addr[31:INDEX_BITS+2];
                req_idx   <= bus.cpu_addr[INDEX_BITS+1:2];
                req_we    <= bus.cpu_we;
                req_wdata <= bus.cpu_wdata;
            end
            if (lookup_miss) begin
                mem_addr_q  <= victim_dirty ? victim_addr : fill_addr;
                mem_write_q <= victim_dirty;
                if (victim_dirty) mem_wdata_q <= data_arr[req_idx];
            end
            if (state == WB_WAIT && bus.mem_ready) begin
                mem_addr_q  <= fill_addr;
                mem_write_q <= 1'b0;
            end
            if (state == LOOKUP && hit && req_we) dirty_arr[req_idx] <= 1'b1;
            if (fill_done) begin
                valid_arr[req_idx] <= 1'b1;
                dirty_arr[req_idx] <= req_we;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge cpu_clk) begin
        if (state == LOOKUP && hit && req_we) data_arr[req_idx] <= req_wdata;
        if (fill_done) begin
            data_arr[req_idx] <= req_we ? req_wdata : bus.mem_rdata;
            tag_arr[req_idx]  <= req_tag;
        end
    end
endmodule
